// File: rtl/stage_f_pkg.sv
// Shared fetch-stage types and constants for the ARM/RISC-V pipeline.
package stage_f_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RV_NOP       = 32'h0000_0013;
  localparam logic [31:0] ARM_NOP      = 32'hE1A0_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC priority mux: writeback r15 write, then execute branch, then PC+4.
module fetch_pc_sel
  import stage_f_pkg::*;
(
  input  logic        pc_write_w,
  input  logic [31:0] result_w,
  input  logic        branch_taken_e,
  input  logic [31:0] pc_target_e,
  input  logic [31:0] pc_plus4_f,
  output logic [31:0] pc_next,
  output logic        redirect
);

  always_comb begin
    pc_next  = pc_plus4_f;
    redirect = 1'b0;
    // W is the older instruction, so it wins
    if (pc_write_w) begin
      pc_next  = result_w;
      redirect = 1'b1;
    end else if (branch_taken_e) begin
      pc_next  = pc_target_e;
      redirect = 1'b1;
    end
  end

endmodule

// File: rtl/stage_f.sv
// Fetch stage: PC register, imem req/gnt/rsp FSM and the F/D register RDD.
// FETCH_SKID_EN lets requests issue while StallF is high.
module stage_f
  import stage_f_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = RV_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        BranchTakenE,
  input  logic [31:0] PCTargetE,
  input  logic        PCWriteW,
  input  logic [31:0] ResultW,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemGnt,
  input  logic        ImemRValid,
  input  logic [31:0] ImemRData,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic [31:0] RDD,
  output logic        FetchStallF
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  rdd_q, rdd_d;
  logic [31:0]  ibuf_q, ibuf_d;
  logic         kill_q, kill_d;
  logic [31:0]  pc_next;
  logic         redirect;
  logic         req_ok;
  logic         bypass;
  logic         accept;

  assign PCF      = pc_q;
  assign PCPlus4F = pc_q + 32'd4;
  assign ImemAddr = pc_q;
  assign RDD      = rdd_q;

  fetch_pc_sel u_pc_sel (
    .pc_write_w     (PCWriteW),
    .result_w       (ResultW),
    .branch_taken_e (BranchTakenE),
    .pc_target_e    (PCTargetE),
    .pc_plus4_f     (PCPlus4F),
    .pc_next        (pc_next),
    .redirect       (redirect)
  );

`ifdef FETCH_SKID_EN
  assign req_ok = 1'b1;
`else
  assign req_ok = !StallF;
`endif

  assign ImemReq = !rst && (state_q == REQ) && req_ok;
  assign bypass  = (state_q == WAIT) && ImemRValid
                && !kill_q && !redirect;
  assign FetchStallF = rst || !(bypass || (state_q == DONE));
  assign accept  = !rst && !StallF && !redirect
                && (bypass || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    ibuf_d  = ibuf_q;
    pc_d    = (redirect || accept) ? pc_next : pc_q;
    unique case (state_q)
      REQ: begin
        // only a stale response can show up here
        kill_d = kill_q && !ImemRValid;
        if (ImemReq && ImemGnt) begin
          state_d = WAIT;
          if (redirect) kill_d = 1'b1;
        end
      end
      WAIT: begin
        if (ImemRValid) begin
          kill_d = 1'b0;
          if (kill_q || redirect || accept) begin
            state_d = REQ;
          end else begin
            state_d = DONE;
            ibuf_d  = ImemRData;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      DONE: begin
        if (redirect || accept) state_d = REQ;
      end
      default: state_d = REQ;
    endcase

    rdd_d = NOP_INSTR;
    if (FlushD)      rdd_d = NOP_INSTR;
    else if (StallD) rdd_d = rdd_q;
    else if (accept) rdd_d = bypass ? ImemRData : ibuf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      rdd_q   <= NOP_INSTR;
      ibuf_q  <= NOP_INSTR;
      // a response still in flight must be dropped
      kill_q  <= (state_q == WAIT) || (kill_q && !ImemRValid);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rdd_q   <= rdd_d;
      ibuf_q  <= ibuf_d;
      kill_q  <= kill_d;
    end
  end

endmodule

// File: tb/tb_stage_f.sv
// Directed bench for stage_f with a reactive memory and a PCD-based model.
module tb_stage_f;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0;
  logic        BranchTakenE = 1'b0, PCWriteW = 1'b0;
  logic [31:0] PCTargetE = '0, ResultW = '0;
  logic        ImemReq, ImemGnt, ImemRValid, FetchStallF;
  logic [31:0] ImemAddr, ImemRData, PCF, PCPlus4F, RDD;

  int          n_chk = 0, n_fail = 0;
  int          gnt_lat = 0, rsp_lat = 1, wait_cnt = 0, pend_cnt = 0;
  logic        pend = 1'b0, stale_v = 1'b0;
  logic [31:0] pend_addr = '0, pcd = '0;
  bit          seen_bad = 1'b0;

  stage_f dut (
    .clk(clk), .rst(rst),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .BranchTakenE(BranchTakenE), .PCTargetE(PCTargetE),
    .PCWriteW(PCWriteW), .ResultW(ResultW),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemGnt(ImemGnt),
    .ImemRValid(ImemRValid), .ImemRData(ImemRData),
    .PCF(PCF), .PCPlus4F(PCPlus4F), .RDD(RDD),
    .FetchStallF(FetchStallF)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return {16'hC0DE, a[15:0]};
  endfunction

  // memory: grant after gnt_lat refused cycles, answer rsp_lat cycles later
  assign ImemGnt    = ImemReq && (wait_cnt >= gnt_lat);
  assign ImemRValid = (pend && pend_cnt == 1) || stale_v;
  assign ImemRData  = stale_v ? 32'hDEAD_BEEF : mem_word(pend_addr);

  always @(posedge clk) begin
    if (rst) begin
      pend     <= 1'b0;
      wait_cnt <= 0;
    end else begin
      wait_cnt <= (ImemReq && !ImemGnt) ? wait_cnt + 1 : 0;
      if (ImemReq && ImemGnt) begin
        pend      <= 1'b1;
        pend_addr <= ImemAddr;
        pend_cnt  <= rsp_lat;
      end else if (pend) begin
        if (pend_cnt == 1) pend <= 1'b0;
        else pend_cnt <= pend_cnt - 1;
      end
    end
  end

  // decode-side PC register: RDD must always be NOP or the word at PCD
  always @(posedge clk) if (!StallD) pcd <= PCF;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req", {31'd0, ImemReq}, 32'd0);
      chk("rst_fstall", {31'd0, FetchStallF}, 32'd1);
    end else begin
      chk("pc_plus4", PCPlus4F, PCF + 32'd4);
      if (ImemReq) chk("imem_addr", ImemAddr, PCF);
      if (RDD != NOP) chk("rdd_vs_pcd", RDD, mem_word(pcd));
      if (RDD == mem_word(32'hC) || RDD == 32'hDEAD_BEEF) seen_bad = 1'b1;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nxt(); #1;
    chk("reset_pcf", PCF, 32'h0);
    chk("reset_rdd", RDD, NOP);
    nxt(); rst = 1'b0; #1;                       // c0
    chk("c0_req", {31'd0, ImemReq}, 32'd1);
    chk("c0_addr", ImemAddr, 32'h0);
    nxt(); #1;                                   // c1 bypass
    chk("c1_fstall", {31'd0, FetchStallF}, 32'd0);
    nxt(); #1;                                   // c2
    chk("c2_rdd", RDD, 32'h0050_0093);
    chk("c2_fstall", {31'd0, FetchStallF}, 32'd1);
    chk("c2_pcf", PCF, 32'h4);
    nxt(); gnt_lat = 3; #1;                      // c3 bypass
    chk("c3_fstall", {31'd0, FetchStallF}, 32'd0);
    nxt(); #1;                                   // c4
    chk("c4_rdd", RDD, 32'h0010_0113);
    chk("c4_addr", ImemAddr, 32'h8);
    for (int i = 0; i < 2; i++) begin            // c5, c6 refused
      nxt(); #1;
      chk("gnt_wait_rdd", RDD, NOP);
      chk("gnt_wait_addr", ImemAddr, 32'h8);
      chk("gnt_wait_pcf", PCF, 32'h8);
      chk("gnt_wait_fstall", {31'd0, FetchStallF}, 32'd1);
    end
    nxt();                                       // c7 granted
    nxt(); gnt_lat = 0; rsp_lat = 2;             // c8 bypass
    nxt(); #1;                                   // c9
    chk("c9_rdd", RDD, 32'hC0DE_0008);
    chk("c9_pcf", PCF, 32'hC);
    nxt(); BranchTakenE = 1'b1; PCTargetE = 32'h100;  // c10 WAIT
    nxt(); BranchTakenE = 1'b0; rsp_lat = 1; #1;      // c11 drop
    chk("c11_pcf", PCF, 32'h100);
    nxt(); #1;                                   // c12
    chk("c12_req", {31'd0, ImemReq}, 32'd1);
    chk("c12_addr", ImemAddr, 32'h100);
    chk("c12_rdd", RDD, NOP);
    nxt();                                       // c13
    nxt(); #1;                                   // c14
    chk("c14_rdd", RDD, 32'hC0DE_0100);
    PCWriteW = 1'b1; ResultW = 32'h200;
    BranchTakenE = 1'b1; PCTargetE = 32'h300;
    nxt(); PCWriteW = 1'b0; BranchTakenE = 1'b0; #1;  // c15
    chk("w_beats_e_pcf", PCF, 32'h200);
    nxt(); #1;                                   // c16
    chk("c16_addr", ImemAddr, 32'h200);
    nxt();                                       // c17
    nxt(); #1;                                   // c18
    chk("c18_rdd", RDD, 32'hC0DE_0200);
    StallF = 1'b1; StallD = 1'b1;
    nxt(); #1;                                   // c19
    chk("stalld_rdd1", RDD, 32'hC0DE_0200);
    chk("stallf_pcf", PCF, 32'h204);
    nxt(); #1;                                   // c20
    chk("stalld_rdd2", RDD, 32'hC0DE_0200);
    FlushD = 1'b1;
    nxt(); FlushD = 1'b0; StallF = 1'b0; StallD = 1'b0; #1;  // c21
    chk("flush_beats_stall", RDD, NOP);
    nxt(); StallF = 1'b1; StallD = 1'b1; #1;     // c22 bypass
    chk("c22_fstall", {31'd0, FetchStallF}, 32'd0);
    nxt(); #1;                                   // c23 DONE
    chk("done_fstall", {31'd0, FetchStallF}, 32'd0);
    chk("done_pcf", PCF, 32'h204);
    chk("done_rdd", RDD, NOP);
    nxt(); StallF = 1'b0; StallD = 1'b0; rsp_lat = 3;  // c24
    nxt(); #1;                                   // c25
    chk("ibuf_rdd", RDD, 32'hC0DE_0204);
    chk("c25_pcf", PCF, 32'h208);
    nxt(); rst = 1'b1; rsp_lat = 1;              // c26 WAIT
    nxt(); rst = 1'b0; stale_v = 1'b1; #1;       // c27
    chk("post_rst_pcf", PCF, 32'h0);
    chk("post_rst_rdd", RDD, NOP);
    chk("post_rst_req", {31'd0, ImemReq}, 32'd1);
    nxt(); stale_v = 1'b0;                       // c28
    nxt(); #1;                                   // c29
    chk("post_rst_word", RDD, 32'h0050_0093);
    chk("c29_pcf", PCF, 32'h4);
    BranchTakenE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    nxt(); BranchTakenE = 1'b0; #1;              // c30
    chk("wrap_pcf", PCF, 32'hFFFF_FFFC);
    chk("wrap_plus4", PCPlus4F, 32'h0);
    nxt(); nxt(); nxt(); #1;                     // c33
    chk("wrap_rdd", RDD, 32'hC0DE_FFFC);
    chk("wrap_next_pcf", PCF, 32'h0);
    chk("no_killed_word", {31'd0, seen_bad}, 32'd0);
    nxt(); nxt();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
